// File: rtl/ring_queue.sv
// Circular FIFO with registered read data, occupancy count and sticky error flags.
// Optional head-of-queue peek outputs are enabled by defining RING_QUEUE_PEEK_EN.
module ring_queue #(
  parameter int data_width  = 2,
  parameter int depth       = 256,
  parameter int afull_level = depth - 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enqueue,
  input  logic                    dequeue,
  input  logic [data_width-1:0]   data_in,
  output logic [data_width-1:0]   data_out,
  output logic                    valid_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic [$clog2(depth):0]  count,
  output logic                    overflow,
  output logic                    underflow
`ifdef RING_QUEUE_PEEK_EN
  ,
  output logic [data_width-1:0]   peek_data,
  output logic                    peek_valid
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] ptr_zero_c = AW'(0);
  localparam logic [AW-1:0] ptr_one_c  = AW'(1);
  localparam logic [CW-1:0] cnt_zero_c = CW'(0);
  localparam logic [CW-1:0] cnt_one_c  = CW'(1);
  localparam logic [CW-1:0] depth_c    = CW'(depth);
  localparam logic [CW-1:0] afull_c    = CW'(afull_level);

  logic [data_width-1:0] mem_q [depth];

  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [data_width-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  assign empty_s  = (count_q == cnt_zero_c);
  assign full_s   = (count_q == depth_c);
  // A full queue still takes a write when a read frees the slot in the same cycle.
  assign rd_acc_s = !flush && dequeue && !empty_s;
  assign wr_acc_s = !flush && enqueue && (!full_s || dequeue);

  // Next-state computation for pointers, occupancy, read data and error flags.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (flush) begin
      head_d  = ptr_zero_c;
      tail_d  = ptr_zero_c;
      count_d = cnt_zero_c;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (rd_acc_s) begin
        data_out_d = mem_q[head_q];
        valid_d    = 1'b1;
        head_d     = head_q + ptr_one_c;
      end else begin
        data_out_d = data_out_q;
        valid_d    = 1'b0;
      end
      if (wr_acc_s) begin
        tail_d = tail_q + ptr_one_c;
      end else begin
        tail_d = tail_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + cnt_one_c;
        2'b01:   count_d = count_q - cnt_one_c;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q || (enqueue && !wr_acc_s);
      unf_d = unf_q || (dequeue && empty_s);
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= ptr_zero_c;
      tail_q     <= ptr_zero_c;
      count_q    <= cnt_zero_c;
      data_out_q <= {data_width{1'b0}};
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[tail_q] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (count_q >= afull_c);
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

`ifdef RING_QUEUE_PEEK_EN
  assign peek_data  = mem_q[head_q];
  assign peek_valid = !empty_s;
`endif

endmodule

// File: tb/tb_ring_queue.sv
// Directed self-checking bench for ring_queue (depth 4, almost_full at 3).
// Build with RING_QUEUE_PEEK_EN defined to also check the peek outputs.
module tb_ring_queue;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       enqueue;
  logic       dequeue;
  logic [1:0] data_in;
  logic [1:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;
`ifdef RING_QUEUE_PEEK_EN
  logic [1:0] peek_data;
  logic       peek_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ring_queue #(
    .data_width (2),
    .depth      (4),
    .afull_level(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .enqueue    (enqueue),
    .dequeue    (dequeue),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef RING_QUEUE_PEEK_EN
    ,
    .peek_data  (peek_data),
    .peek_valid (peek_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given requests; returns 1 time unit after the edge.
  task automatic cyc(input logic enq, input logic deq, input logic [1:0] din, input logic fl);
    enqueue = enq;
    dequeue = deq;
    data_in = din;
    flush   = fl;
    @(posedge clk);
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    enqueue = 1'b0;
    dequeue = 1'b0;
    data_in = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 32'd0);
    chk("rst_empty", empty, 32'd1);
    chk("rst_full", full, 32'd0);
    chk("rst_afull", almost_full, 32'd0);
    chk("rst_valid", valid_out, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_ovf", overflow, 32'd0);
    chk("rst_unf", underflow, 32'd0);
    rst = 1'b0;

    // In-order fill and drain
    cyc(1'b1, 1'b0, 2'd1, 1'b0); chk("fill1_count", count, 32'd1); chk("fill1_empty", empty, 32'd0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0); chk("fill2_count", count, 32'd2);
    cyc(1'b1, 1'b0, 2'd3, 1'b0); chk("fill3_count", count, 32'd3);
    cyc(1'b1, 1'b0, 2'd0, 1'b0); chk("fill4_count", count, 32'd4); chk("fill4_full", full, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("drain1_data", data_out, 32'd1); chk("drain1_valid", valid_out, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("drain2_data", data_out, 32'd2); chk("drain2_valid", valid_out, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("drain3_data", data_out, 32'd3); chk("drain3_valid", valid_out, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("drain4_data", data_out, 32'd0); chk("drain4_empty", empty, 32'd1);
    chk("drain4_count", count, 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0); chk("idle_valid", valid_out, 32'd0);

    // Thresholds and overflow
    cyc(1'b1, 1'b0, 2'd1, 1'b0); chk("af1_afull", almost_full, 32'd0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0); chk("af2_afull", almost_full, 32'd0); chk("af2_count", count, 32'd2);
    cyc(1'b1, 1'b0, 2'd3, 1'b0); chk("af3_afull", almost_full, 32'd1); chk("af3_full", full, 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0); chk("af4_full", full, 32'd1); chk("af4_ovf", overflow, 32'd0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0); chk("ovf_count", count, 32'd4); chk("ovf_flag", overflow, 32'd1);

    // Simultaneous read/write while full
    cyc(1'b1, 1'b1, 2'd2, 1'b0); chk("fullrw_data", data_out, 32'd1); chk("fullrw_valid", valid_out, 32'd1);
    chk("fullrw_count", count, 32'd4);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("fr1_data", data_out, 32'd2);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("fr2_data", data_out, 32'd3);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("fr3_data", data_out, 32'd0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("fr4_data", data_out, 32'd2); chk("fr4_empty", empty, 32'd1);

    // Simultaneous read/write while empty
    cyc(1'b1, 1'b1, 2'd3, 1'b0); chk("emptyrw_valid", valid_out, 32'd0); chk("emptyrw_count", count, 32'd1);
    chk("emptyrw_unf", underflow, 32'd1); chk("emptyrw_hold", data_out, 32'd2);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("emptyrw_rd", data_out, 32'd3); chk("emptyrw_rdv", valid_out, 32'd1);

    // Flush, then interleaved traffic across the wrap point
    cyc(1'b0, 1'b0, 2'd0, 1'b1); chk("fl_ovf", overflow, 32'd0); chk("fl_unf", underflow, 32'd0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 2'd3, 1'b0); chk("il_count3", count, 32'd3);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd1", data_out, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd2", data_out, 32'd2);
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd3", data_out, 32'd3);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd4", data_out, 32'd0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd5", data_out, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("il_rd6", data_out, 32'd2); chk("il_empty", empty, 32'd1);
    cyc(1'b1, 1'b0, 2'd3, 1'b0);
    cyc(1'b1, 1'b0, 2'd1, 1'b0); chk("pre_fl_count", count, 32'd2);
    cyc(1'b1, 1'b0, 2'd2, 1'b1); chk("flw_count", count, 32'd0); chk("flw_empty", empty, 32'd1);
    chk("flw_ovf", overflow, 32'd0); chk("flw_valid", valid_out, 32'd0); chk("flw_hold", data_out, 32'd2);

    // Asynchronous reset between edges
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("ar_unf", underflow, 32'd1);
    cyc(1'b1, 1'b0, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 2'd3, 1'b0);
`ifdef RING_QUEUE_PEEK_EN
    chk("peek_head1", peek_data, 32'd1); chk("peek_valid1", peek_valid, 32'd1);
`endif
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("ar_rd", data_out, 32'd1); chk("ar_count", count, 32'd2);
`ifdef RING_QUEUE_PEEK_EN
    chk("peek_head2", peek_data, 32'd2);
`endif
    #3;
    rst = 1'b1;
    #1;
    chk("ar_count0", count, 32'd0);
    chk("ar_empty", empty, 32'd1);
    chk("ar_afull", almost_full, 32'd0);
    chk("ar_data0", data_out, 32'd0);
    chk("ar_valid0", valid_out, 32'd0);
    chk("ar_unf0", underflow, 32'd0);
`ifdef RING_QUEUE_PEEK_EN
    chk("peek_valid0", peek_valid, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 2'd2, 1'b0); chk("post_count", count, 32'd1);
    cyc(1'b0, 1'b1, 2'd0, 1'b0); chk("post_data", data_out, 32'd2); chk("post_valid", valid_out, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
